// File: rtl/text_console_pkg.sv
// Shared geometry, character constants and state encoding for the text console writer.
package text_console_pkg;

    localparam int unsigned COLUMNS = 80;
    localparam int unsigned ROWS    = 30;
    localparam int unsigned CELLS   = COLUMNS * ROWS;

    localparam int unsigned COL_W  = 7;
    localparam int unsigned ROW_W  = 5;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned CODE_W = 7;

    localparam logic [CODE_W-1:0] BLANK_CODE = 7'h20;

    localparam logic [7:0] ASCII_BS       = 8'h08;
    localparam logic [7:0] ASCII_TAB      = 8'h09;
    localparam logic [7:0] ASCII_LF       = 8'h0A;
    localparam logic [7:0] ASCII_FF       = 8'h0C;
    localparam logic [7:0] ASCII_CR       = 8'h0D;
    localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
    localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

    localparam logic [COL_W-1:0]  LAST_COL     = COL_W'(COLUMNS - 1);
    localparam logic [COL_W-1:0]  TAB_WRAP_COL = COL_W'(COLUMNS - 8);
    localparam logic [ROW_W-1:0]  LAST_ROW     = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE   = ADDR_W'(COLUMNS);
    localparam logic [ADDR_W-1:0] CELL_COUNT   = ADDR_W'(CELLS);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR_LINE,
        CLEAR_ALL
    } state_t;

endpackage

// File: rtl/cell_filler.sv
// Emits one blank-cell write per cycle over a contiguous address range.
// Comes out of reset already running a full-screen fill.
module cell_filler
    import text_console_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [ADDR_W-1:0] count_i,
    output logic              wr_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              done_o
);

    logic              active_q, active_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] left_q, left_d;

    always_comb begin
        active_d = active_q;
        addr_d   = addr_q;
        left_d   = left_q;
        if (start_i) begin
            active_d = 1'b1;
            addr_d   = start_addr_i;
            left_d   = count_i - 1'b1;
        end else if (active_q) begin
            if (left_q == '0) begin
                active_d = 1'b0;
            end else begin
                addr_d = addr_q + 1'b1;
                left_d = left_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            active_q <= 1'b1;
            addr_q   <= '0;
            left_q   <= CELL_COUNT - 1'b1;
        end else begin
            active_q <= active_d;
            addr_q   <= addr_d;
            left_q   <= left_d;
        end
    end

    assign wr_o   = active_q;
    assign addr_o = addr_q;
    assign done_o = active_q && (left_q == '0);

endmodule

// File: rtl/text_console_writer.sv
// Turns an ASCII byte stream into single-cell display buffer writes,
// tracking the cursor and handling control codes, wrap and screen clears.
module text_console_writer
    import text_console_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_char,
    output logic              in_ready,
    output logic              buffer_write_enable,
    output logic [ADDR_W-1:0] position,
    output logic [CODE_W-1:0] char_code,
    output logic [ROW_W-1:0]  cursor_row,
    output logic [COL_W-1:0]  cursor_col
);

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] pos_q, pos_d;
    logic [CODE_W-1:0] code_q, code_d;

    logic              fill_start;
    logic [ADDR_W-1:0] fill_start_addr;
    logic [ADDR_W-1:0] fill_count;
    logic              fill_wr;
    logic [ADDR_W-1:0] fill_wr_addr;
    logic              fill_done;

    logic              newline;
    logic              wrap_row;
    logic [ROW_W-1:0]  next_row;
    logic [ADDR_W-1:0] next_base;
    logic [ADDR_W-1:0] cur_pos;

    // row_base tracks row*COLUMNS incrementally so no multiplier is needed
    assign wrap_row  = (row_q == LAST_ROW);
    assign next_row  = wrap_row ? '0 : row_q + 1'b1;
    assign next_base = wrap_row ? '0 : base_q + ROW_STRIDE;
    assign cur_pos   = base_q + ADDR_W'(col_q);

    always_comb begin
        state_d         = state_q;
        row_d           = row_q;
        col_d           = col_q;
        base_d          = base_q;
        we_d            = 1'b0;
        pos_d           = pos_q;
        code_d          = code_q;
        fill_start      = 1'b0;
        fill_start_addr = '0;
        fill_count      = ROW_STRIDE;
        newline         = 1'b0;

        case (state_q)
            CLEAR_ALL, CLEAR_LINE: begin
                we_d   = fill_wr;
                pos_d  = fill_wr_addr;
                code_d = BLANK_CODE;
                if (fill_done) state_d = IDLE;
            end
            IDLE: begin
                if (in_valid) begin
                    if (in_char >= ASCII_PRINT_LO && in_char <= ASCII_PRINT_HI) begin
                        we_d   = 1'b1;
                        pos_d  = cur_pos;
                        code_d = in_char[6:0];
                        if (col_q == LAST_COL) newline = 1'b1;
                        else                   col_d   = col_q + 1'b1;
                    end else begin
                        case (in_char)
                            ASCII_LF: newline = 1'b1;
                            ASCII_CR: col_d = '0;
                            ASCII_BS: begin
                                if (col_q != '0) begin
                                    col_d  = col_q - 1'b1;
                                    we_d   = 1'b1;
                                    pos_d  = cur_pos - 1'b1;
                                    code_d = BLANK_CODE;
                                end
                            end
                            ASCII_TAB: begin
                                if (col_q >= TAB_WRAP_COL) newline = 1'b1;
                                else col_d = {col_q[COL_W-1:3] + 1'b1, 3'b000};
                            end
                            ASCII_FF: begin
                                row_d           = '0;
                                col_d           = '0;
                                base_d          = '0;
                                state_d         = CLEAR_ALL;
                                fill_start      = 1'b1;
                                fill_start_addr = '0;
                                fill_count      = CELL_COUNT;
                            end
                            default: ;
                        endcase
                    end
                    if (newline) begin
                        col_d           = '0;
                        row_d           = next_row;
                        base_d          = next_base;
                        state_d         = CLEAR_LINE;
                        fill_start      = 1'b1;
                        fill_start_addr = next_base;
                        fill_count      = ROW_STRIDE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= CLEAR_ALL;
            row_q   <= '0;
            col_q   <= '0;
            base_q  <= '0;
            we_q    <= 1'b0;
            pos_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            base_q  <= base_d;
            we_q    <= we_d;
            pos_q   <= pos_d;
            code_q  <= code_d;
        end
    end

    cell_filler u_filler (
        .clk_i        (clk),
        .rst_ni       (reset),
        .start_i      (fill_start),
        .start_addr_i (fill_start_addr),
        .count_i      (fill_count),
        .wr_o         (fill_wr),
        .addr_o       (fill_wr_addr),
        .done_o       (fill_done)
    );

    assign in_ready            = (state_q == IDLE);
    assign buffer_write_enable = we_q;
    assign position            = pos_q;
    assign char_code           = code_q;
    assign cursor_row          = row_q;
    assign cursor_col          = col_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench for text_console_writer: stimulus queues expected writes,
// a negedge monitor pops and compares every write strobe.
module tb_text_console_writer;
    import text_console_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_char = 8'h00;
    logic              in_ready;
    logic              buffer_write_enable;
    logic [ADDR_W-1:0] position;
    logic [CODE_W-1:0] char_code;
    logic [ROW_W-1:0]  cursor_row;
    logic [COL_W-1:0]  cursor_col;

    typedef struct {
        logic [11:0] addr;
        logic [6:0]  code;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          tests = 0;
    int          fails = 0;
    int unsigned wr_count = 0;

    text_console_writer dut (
        .clk                 (clk),
        .reset               (reset),
        .in_valid            (in_valid),
        .in_char             (in_char),
        .in_ready            (in_ready),
        .buffer_write_enable (buffer_write_enable),
        .position            (position),
        .char_code           (char_code),
        .cursor_row          (cursor_row),
        .cursor_col          (cursor_col)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (buffer_write_enable === 1'b1) begin
            wr_count++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got pos=%0d code=%h, required no write", position, char_code);
            end else begin
                mon_e = exp_q.pop_front();
                if (position !== mon_e.addr || char_code !== mon_e.code) begin
                    fails++;
                    $display("FAIL write: got pos=%0d code=%h, required pos=%0d code=%h",
                             position, char_code, mon_e.addr, mon_e.code);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic check_cursor(input string name, input int r, input int c);
        check({name, "_row"}, 32'(cursor_row), r);
        check({name, "_col"}, 32'(cursor_col), c);
    endtask

    task automatic exp_wr(input int a, input int c);
        wr_t w;
        w.addr = 12'(a);
        w.code = 7'(c);
        exp_q.push_back(w);
    endtask

    task automatic exp_blank(input int start, input int n);
        for (int i = 0; i < n; i++) exp_wr(start + i, 'h20);
    endtask

    task automatic send(input logic [7:0] c);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_char  = c;
        while (!in_ready && n < 5000) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0, required 1 within 5000 cycles");
        end else begin
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_ready(output int n, input int budget);
        n = 0;
        while (!in_ready && n < budget) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got in_ready=0, required 1 within %0d cycles", budget);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_we"},    32'(buffer_write_enable), 0);
        check({name, "_pos"},   32'(position), 0);
        check({name, "_code"},  32'(char_code), 0);
        check({name, "_ready"}, 32'(in_ready), 0);
        check_cursor(name, 0, 0);
    endtask

    initial begin
        int n;
        int unsigned base_cnt;

        reset = 1'b0;
        repeat (3) tick();
        check_reset_outputs("rst");

        // 1: power-up clear of all 2400 cells
        exp_blank(0, 2400);
        reset = 1'b1;
        wait_ready(n, 3000);
        check("t1_fill_cycles", n, 2400);
        tick();
        check("t1_drained", exp_q.size(), 0);
        check_cursor("t1", 0, 0);

        // 2: back-to-back printable bytes
        exp_wr(0, 'h41);
        exp_wr(1, 'h42);
        send(8'h41);
        check("t2_ready_held", 32'(in_ready), 1);
        send(8'h42);
        check_cursor("t2", 0, 2);

        // 3: auto-wrap from column 79
        for (int i = 2; i <= 78; i++) begin
            exp_wr(i, 'h2E);
            send(8'h2E);
        end
        check_cursor("t3_pre", 0, 79);
        exp_wr(79, 'h5A);
        exp_blank(80, 80);
        send(8'h5A);
        wait_ready(n, 200);
        check("t3_busy_cycles", n, 80);
        check_cursor("t3", 1, 0);
        tick();
        check("t3_drained", exp_q.size(), 0);

        // 4: LF from the last row wraps to row 0; CR is write-free
        for (int r = 2; r <= 29; r++) begin
            exp_blank(r * 80, 80);
            send(ASCII_LF);
            wait_ready(n, 200);
        end
        for (int i = 0; i < 5; i++) begin
            exp_wr(2320 + i, 'h61 + i);
            send(8'(8'h61 + i));
        end
        check_cursor("t4_pre", 29, 5);
        exp_blank(0, 80);
        send(ASCII_LF);
        wait_ready(n, 200);
        check("t4_lf_cycles", n, 80);
        check_cursor("t4_lf", 0, 0);
        for (int i = 0; i < 5; i++) begin
            exp_wr(i, 'h76);
            send(8'h76);
        end
        send(ASCII_CR);
        repeat (3) tick();
        check_cursor("t4_cr", 0, 0);
        check("t4_drained", exp_q.size(), 0);

        // 5: backspace, tab, unknown control, tab wrap
        for (int r = 1; r <= 3; r++) begin
            exp_blank(r * 80, 80);
            send(ASCII_LF);
            wait_ready(n, 200);
        end
        for (int i = 0; i < 10; i++) begin
            exp_wr(240 + i, 'h6B);
            send(8'h6B);
        end
        check_cursor("t5_pre", 3, 10);
        exp_wr(249, 'h20);
        send(ASCII_BS);
        check_cursor("t5_bs", 3, 9);
        send(ASCII_CR);
        send(ASCII_BS);
        check_cursor("t5_bs0", 3, 0);
        for (int i = 0; i < 10; i++) begin
            exp_wr(240 + i, 'h30 + i);
            send(8'(8'h30 + i));
        end
        send(ASCII_TAB);
        check_cursor("t5_tab", 3, 16);
        send(8'h01);
        check_cursor("t5_other", 3, 16);
        for (int i = 0; i < 56; i++) begin
            exp_wr(256 + i, 'h2D);
            send(8'h2D);
        end
        check_cursor("t5_pre_tab72", 3, 72);
        exp_blank(320, 80);
        send(ASCII_TAB);
        wait_ready(n, 200);
        check_cursor("t5_tab72", 4, 0);
        tick();
        check("t5_drained", exp_q.size(), 0);

        // 6: form feed, then reset halfway through the clear
        for (int i = 0; i < 3; i++) begin
            exp_wr(320 + i, 'h51);
            send(8'h51);
        end
        check_cursor("t6_pre", 4, 3);
        exp_blank(0, 2400);
        base_cnt = wr_count;
        send(ASCII_FF);
        check_cursor("t6_ff", 0, 0);
        check("t6_ff_busy", 32'(in_ready), 0);
        n = 0;
        while (wr_count < base_cnt + 1200 && n < 2000) begin
            tick();
            n++;
        end
        check("t6_half_reached", 32'(wr_count >= base_cnt + 1200), 1);
        reset = 1'b0;
        tick();
        check_reset_outputs("t6_rst");
        exp_q.delete();
        tick();
        exp_blank(0, 2400);
        reset = 1'b1;
        wait_ready(n, 3000);
        check("t6_refill_cycles", n, 2400);
        tick();
        check("t6_drained", exp_q.size(), 0);
        check_cursor("t6_end", 0, 0);

        repeat (5) tick();
        check("final_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
